// File: rtl/data_cache_ctrl.sv
// Sequencing controller for the L0 data cache: core handshake, search strobe,
// block refill request/tracking, round-robin replacement pointer and write-back throttle.
module data_cache_ctrl #(
    parameter int LOG2_NUM_BLKS       = 3,
    parameter int LOG2_WORDS_IN_BLOCK = 2,
    parameter int MAX_DIRTY           = 4,
    parameter int LOW_DIRTY           = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     core_req_i,
    input  logic                     core_we_i,
    input  logic [31:0]              core_addr_i,
    output logic                     core_gnt_o,
    output logic                     core_rvalid_o,
    output logic                     search_o,
    input  logic                     miss_i,
    input  logic [LOG2_NUM_BLKS:0]   dirty_num_i,
    output logic [LOG2_NUM_BLKS-1:0] rplc_line_idx_o,
    output logic                     write_to_mem_o,
    output logic                     mem_req_o,
    output logic [31:0]              mem_addr_o,
    input  logic                     mem_gnt_i,
    input  logic                     data_rvalid_i,
    output logic [1:0]               fsm_state
);

    localparam int OFF = LOG2_WORDS_IN_BLOCK + 2;
    localparam int DW  = LOG2_NUM_BLKS + 1;
    localparam logic [DW-1:0]            MAX_W   = DW'(MAX_DIRTY);
    localparam logic [DW-1:0]            LOW_W   = DW'(LOW_DIRTY);
    localparam logic [LOG2_NUM_BLKS-1:0] PTR_ONE = LOG2_NUM_BLKS'(1);

    // Debug encoding on fsm_state: 0 = IDLE, 1 = MISS_REQ, 2 = MISS_WAIT.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2
    } state_t;

    state_t state;
    logic   hit_rvalid;
    logic   refill_done;

    // Stores complete the same way loads do, and the block offset is dropped
    // from the refill address, so these inputs carry no extra information here.
    logic unused_inputs;
    assign unused_inputs = ^{core_we_i, core_addr_i[OFF-1:0]};

    // Refill data may land in the very cycle RAM grants the request.
    always_comb begin
        refill_done = 1'b0;
        if (data_rvalid_i && (state == MISS_WAIT || (state == MISS_REQ && mem_gnt_i)))
            refill_done = 1'b1;
    end

    assign core_gnt_o    = (state == IDLE) && core_req_i;
    assign search_o      = (state == IDLE) && core_req_i;
    assign core_rvalid_o = hit_rvalid | refill_done;
    assign fsm_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hit_rvalid      <= 1'b0;
            mem_req_o       <= 1'b0;
            mem_addr_o      <= '0;
            rplc_line_idx_o <= '0;
        end else begin
            hit_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req_i) begin
                        if (miss_i) begin
                            mem_addr_o <= {core_addr_i[31:OFF], {OFF{1'b0}}};
                            mem_req_o  <= 1'b1;
                            state      <= MISS_REQ;
                        end else begin
                            hit_rvalid <= 1'b1;
                        end
                    end
                end
                MISS_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state     <= data_rvalid_i ? IDLE : MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (data_rvalid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Pointer only moves once the refilled line has been written.
            if (refill_done)
                rplc_line_idx_o <= rplc_line_idx_o + PTR_ONE;
        end
    end

    // Hysteresis between the two watermarks keeps write-back from chattering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_to_mem_o <= 1'b0;
        end else if (dirty_num_i > MAX_W) begin
            write_to_mem_o <= 1'b1;
        end else if (dirty_num_i <= LOW_W) begin
            write_to_mem_o <= 1'b0;
        end
    end

endmodule
